// File: rtl/pam_fetch_unit.sv
// PAM stack-processor fetch front end: PC, imem read sequencing, decode handshake and return-address stack.
// Build option FETCH_STACK_WRAP_EN: circular return stack, so overflow warns instead of halting.
module pam_fetch_unit #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 12,
    parameter int STACK_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic [ADDR_WIDTH-1:0]   imem_addr,
    output logic                    imem_rd_en,
    input  logic [2*DATA_WIDTH-1:0] imem_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_instr,
    output logic [DATA_WIDTH-1:0]   out_arg,
    output logic [ADDR_WIDTH-1:0]   out_pc,
    input  logic                    redir_valid,
    input  logic [1:0]              redir_op,
    input  logic [ADDR_WIDTH-1:0]   redir_target,
    input  logic [DATA_WIDTH-1:0]   redir_offset,
    output logic                    stack_ovf,
    output logic                    stack_unf,
    output logic                    halted
);

    localparam int SP_W = $clog2(STACK_DEPTH);
    localparam logic [SP_W:0] SP_FULL = (SP_W+1)'(STACK_DEPTH);
    localparam logic [SP_W:0] SP_ONE  = (SP_W+1)'(1);

`ifdef FETCH_STACK_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    localparam logic [1:0] OP_JUMP   = 2'b00;
    localparam logic [1:0] OP_BRANCH = 2'b01;
    localparam logic [1:0] OP_CALL   = 2'b10;

    typedef enum logic [1:0] {ST_ISSUE, ST_WAIT, ST_HOLD, ST_HALT} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] out_pc_q;
    logic [DATA_WIDTH-1:0] out_instr_q;
    logic [DATA_WIDTH-1:0] out_arg_q;
    logic                  out_valid_q;
    logic                  ovf_q;
    logic                  unf_q;
    logic                  halted_q;
    logic [SP_W:0]         sp_q;
    logic [SP_W-1:0]       top_q;
    logic [ADDR_WIDTH-1:0] ras_q [STACK_DEPTH];

    logic                  redir_act;
    logic                  stack_full;
    logic                  stack_empty;
    logic                  push_en;
    logic [SP_W-1:0]       top_dec;
    logic [ADDR_WIDTH-1:0] ret_addr;
    logic [ADDR_WIDTH-1:0] branch_pc;
    logic [ADDR_WIDTH-1:0] pop_addr;

    // Redirects are relative to the instruction decode is looking at, not to the fetch PC.
    assign redir_act   = redir_valid && (state_q != ST_HALT);
    assign stack_full  = (sp_q == SP_FULL);
    assign stack_empty = (sp_q == '0);
    assign ret_addr    = out_pc_q + ADDR_WIDTH'(1);
    assign branch_pc   = out_pc_q + ADDR_WIDTH'($signed(redir_offset));
    assign top_dec     = top_q - SP_W'(1);
    assign pop_addr    = ras_q[top_dec];
    assign push_en     = !reset && redir_act && (redir_op == OP_CALL) && (!stack_full || WRAP_EN);

    assign imem_addr  = pc_q;
    assign imem_rd_en = (state_q == ST_ISSUE) && !reset;
    assign out_valid  = out_valid_q;
    assign out_instr  = out_instr_q;
    assign out_arg    = out_arg_q;
    assign out_pc     = out_pc_q;
    assign stack_ovf  = ovf_q;
    assign stack_unf  = unf_q;
    assign halted     = halted_q;

    // top_q is the next free slot; when full it aliases the oldest entry, which wrap mode overwrites.
    always_ff @(posedge clk) begin
        if (push_en) begin
            ras_q[top_q] <= ret_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_ISSUE;
            pc_q        <= '0;
            sp_q        <= '0;
            top_q       <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_arg_q   <= '0;
            out_pc_q    <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            halted_q    <= 1'b0;
        end else if (redir_act) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_ISSUE;
            case (redir_op)
                OP_JUMP:   pc_q <= redir_target;
                OP_BRANCH: pc_q <= branch_pc;
                OP_CALL: begin
                    if (stack_full && !WRAP_EN) begin
                        ovf_q    <= 1'b1;
                        halted_q <= 1'b1;
                        state_q  <= ST_HALT;
                    end else begin
                        if (stack_full) begin
                            ovf_q <= 1'b1;
                        end else begin
                            sp_q <= sp_q + SP_ONE;
                        end
                        top_q <= top_q + SP_W'(1);
                        pc_q  <= redir_target;
                    end
                end
                default: begin
                    if (stack_empty) begin
                        unf_q    <= 1'b1;
                        halted_q <= 1'b1;
                        state_q  <= ST_HALT;
                    end else begin
                        sp_q  <= sp_q - SP_ONE;
                        top_q <= top_dec;
                        pc_q  <= pop_addr;
                    end
                end
            endcase
        end else begin
            case (state_q)
                ST_ISSUE: state_q <= ST_WAIT;
                ST_WAIT: begin
                    out_instr_q <= imem_data[2*DATA_WIDTH-1:DATA_WIDTH];
                    out_arg_q   <= imem_data[DATA_WIDTH-1:0];
                    out_pc_q    <= pc_q;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        pc_q        <= pc_q + ADDR_WIDTH'(1);
                        state_q     <= ST_ISSUE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
